dcp_rf_dump: RTL and testbench

//  Debug-command handler for the register-dump command. When the command decoder's
//  sel_mode matches CMD_CODE, it reads NUM_REGS consecutive register-file entries from

---
 rtl/dcp_rf_dump.sv | 191 +++++++++++++++++++
 tb/tb_dcp_rf_dump.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcp_rf_dump.sv
// rtl/dcp_rf_dump.sv - register-dump debug command handler streaming RF contents to the UART
//
// Purpose: while sel_mode == CMD_CODE, sends one header byte (CMD_CODE), then for each of
// NUM_REGS registers starting at START_ADDR an index byte (address) followed by the data word.
// Items go out over a req/ack handshake; dropping sel_mode aborts at any point.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   rstn      in   1       asynchronous active-low reset
//   sel_mode  in   8       current command; handler active while == CMD_CODE
//   finish    out  1       dump complete, held until sel_mode leaves CMD_CODE
//   req_tx    out  1       transmit request; dout/type_tx valid while high
//   ack_tx    in   1       one-cycle accept pulse from the transmitter
//   type_tx   out  1       0 = byte item (dout[7:0]), 1 = full DATA_W word
//   dout      out  DATA_W  item to transmit
//   addr      out  ADDR_W  register-file read address
//   din_rf    in   DATA_W  register-file read data, combinational from addr
//   dump_cnt  out  8       completed dumps, wrapping
module dcp_rf_dump #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 5,
    parameter int          NUM_REGS   = 32,
    parameter int          START_ADDR = 0,
    parameter logic [7:0]  CMD_CODE   = 8'h52
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        sel_mode,
    output logic              finish,
    output logic              req_tx,
    input  logic              ack_tx,
    output logic              type_tx,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din_rf,
    output logic [7:0]        dump_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_HWT, S_RD, S_LD, S_IDX, S_IWT, S_DAT, S_DWT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic                finish_q, finish_d;
    logic                req_q, req_d;
    logic                type_q, type_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          cnt_q, cnt_d;

    logic                active;
    logic                ack;
    logic [7:0]          addr_byte;

    assign active = (sel_mode == CMD_CODE);
    // An ack only counts while a request is outstanding.
    assign ack    = ack_tx && req_q;

    // Index byte is the address zero-extended or truncated to 8 bits.
    generate
        if (ADDR_W >= 8) begin : g_addr_trunc
            assign addr_byte = addr_q[7:0];
        end else begin : g_addr_ext
            assign addr_byte = {{(8 - ADDR_W){1'b0}}, addr_q};
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            finish_q <= 1'b0;
            req_q    <= 1'b0;
            type_q   <= 1'b0;
            dout_q   <= '0;
            addr_q   <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            finish_q <= finish_d;
            req_q    <= req_d;
            type_q   <= type_d;
            dout_q   <= dout_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        finish_d = finish_q;
        req_d    = req_q;
        type_d   = type_q;
        dout_d   = dout_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        data_d   = data_q;
        cnt_d    = cnt_q;

        if (!active || state_q == S_IDLE) begin
            // Abort and idle share the same clean-up so req_tx falls on the very next
            // edge after sel_mode leaves, and any acknowledge in that cycle is discarded.
            finish_d = 1'b0;
            req_d    = 1'b0;
            type_d   = 1'b0;
            dout_d   = '0;
            addr_d   = START;
            idx_d    = '0;
            state_d  = active ? S_HDR : S_IDLE;
        end else begin
            case (state_q)
                S_HDR: begin
                    req_d   = 1'b1;
                    type_d  = 1'b0;
                    dout_d  = DATA_W'(CMD_CODE);
                    state_d = S_HWT;
                end
                S_HWT: begin
                    if (ack) begin
                        req_d   = 1'b0;
                        state_d = S_RD;
                    end
                end
                S_RD: begin
                    // Wraps modulo 2**ADDR_W by construction of the operand widths.
                    addr_d  = START + idx_q;
                    state_d = S_LD;
                end
                S_LD: begin
                    // The only point where RF data is sampled.
                    data_d  = din_rf;
                    state_d = S_IDX;
                end
                S_IDX: begin
                    req_d   = 1'b1;
                    type_d  = 1'b0;
                    dout_d  = DATA_W'(addr_byte);
                    state_d = S_IWT;
                end
                S_IWT: begin
                    if (ack) begin
                        req_d   = 1'b0;
                        state_d = S_DAT;
                    end
                end
                S_DAT: begin
                    req_d   = 1'b1;
                    type_d  = 1'b1;
                    dout_d  = data_q;
                    state_d = S_DWT;
                end
                S_DWT: begin
                    if (ack) begin
                        req_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            // Count and flag on entry to DONE only.
                            finish_d = 1'b1;
                            cnt_d    = cnt_q + 8'd1;
                            state_d  = S_DONE;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = S_RD;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign finish   = finish_q;
    assign req_tx   = req_q;
    assign type_tx  = type_q;
    assign dout     = dout_q;
    assign addr     = addr_q;
    assign dump_cnt = cnt_q;

endmodule

// File: tb/tb_dcp_rf_dump.sv
// tb/tb_dcp_rf_dump.sv - scoreboard bench for dcp_rf_dump (default and 16-bit wrapping configs)
module tb_dcp_rf_dump;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic [7:0]  sel_a;
    logic        fin_a, req_a, ack_a, type_a;
    logic [31:0] dout_a, din_a;
    logic [4:0]  addr_a;
    logic [7:0]  cnt_a;
    logic [31:0] rf_a [32];
    assign din_a = rf_a[addr_a];

    // DUT B: 16-bit data, 4 registers from address 30 (wraps)
    logic [7:0]  sel_b;
    logic        fin_b, req_b, ack_b, type_b;
    logic [15:0] dout_b, din_b;
    logic [4:0]  addr_b;
    logic [7:0]  cnt_b;
    logic [15:0] rf_b [32];
    assign din_b = rf_b[addr_b];

    dcp_rf_dump dut_a (
        .clk(clk), .rstn(rstn), .sel_mode(sel_a), .finish(fin_a), .req_tx(req_a),
        .ack_tx(ack_a), .type_tx(type_a), .dout(dout_a), .addr(addr_a),
        .din_rf(din_a), .dump_cnt(cnt_a)
    );

    dcp_rf_dump #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(4), .START_ADDR(30), .CMD_CODE(8'h52)) dut_b (
        .clk(clk), .rstn(rstn), .sel_mode(sel_b), .finish(fin_b), .req_tx(req_b),
        .ack_tx(ack_b), .type_tx(type_b), .dout(dout_b), .addr(addr_b),
        .din_rf(din_b), .dump_cnt(cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: {type, data}
    logic [32:0] exp_a [$];
    logic [16:0] exp_b [$];

    // Transmitter model / monitor for A
    logic        mon_ack_a = 1'b0;
    logic        spur_pend_a = 1'b0;
    logic        spur_en_a = 1'b0;
    logic        prev_req_a = 1'b0;
    int          ack_dly_a = 2;
    int          since_a = 0;
    int          rx_a = 0;
    int          stall_a = -1;
    logic [37:0] cap_a = '0;
    assign ack_a = mon_ack_a;

    always @(negedge clk) begin
        mon_ack_a = 1'b0;
        if (spur_pend_a) begin
            mon_ack_a   = 1'b1;
            spur_pend_a = 1'b0;
        end
        if (!rstn) begin
            prev_req_a = 1'b0;
        end else if (req_a) begin
            if (!prev_req_a) begin
                rx_a++;
                since_a = 0;
                cap_a   = {type_a, dout_a, addr_a};
                if (exp_a.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_item: unexpected item type=%0d dout=%h", type_a, dout_a);
                end else begin
                    check("a_item", {type_a, dout_a}, exp_a.pop_front());
                end
            end else begin
                since_a++;
                check("a_stable", {type_a, dout_a, addr_a}, cap_a);
            end
            if (since_a == ack_dly_a && rx_a != stall_a) begin
                mon_ack_a   = 1'b1;
                spur_pend_a = spur_en_a;
            end
        end
        prev_req_a = req_a;
    end

    // Transmitter model / monitor for B
    logic        mon_ack_b = 1'b0;
    logic        prev_req_b = 1'b0;
    int          since_b = 0;
    logic [21:0] cap_b = '0;
    assign ack_b = mon_ack_b;

    always @(negedge clk) begin
        mon_ack_b = 1'b0;
        if (!rstn) begin
            prev_req_b = 1'b0;
        end else if (req_b) begin
            if (!prev_req_b) begin
                since_b = 0;
                cap_b   = {type_b, dout_b, addr_b};
                if (exp_b.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_item: unexpected item type=%0d dout=%h", type_b, dout_b);
                end else begin
                    check("b_item", {type_b, dout_b}, exp_b.pop_front());
                end
            end else begin
                since_b++;
                check("b_stable", {type_b, dout_b, addr_b}, cap_b);
            end
            if (since_b == 3) mon_ack_b = 1'b1;
        end
        prev_req_b = req_b;
    end

    task automatic push_dump_a();
        exp_a.push_back({1'b0, 32'h0000_0052});
        for (int i = 0; i < 32; i++) begin
            exp_a.push_back({1'b0, 32'(i)});
            exp_a.push_back({1'b1, 32'hA000_0000 + 32'(i)});
        end
    endtask

    task automatic push_dump_b();
        exp_b.push_back({1'b0, 16'h0052});
        exp_b.push_back({1'b0, 16'h001E}); exp_b.push_back({1'b1, 16'hDE1E});
        exp_b.push_back({1'b0, 16'h001F}); exp_b.push_back({1'b1, 16'hDF1F});
        exp_b.push_back({1'b0, 16'h0000}); exp_b.push_back({1'b1, 16'hC000});
        exp_b.push_back({1'b0, 16'h0001}); exp_b.push_back({1'b1, 16'hC101});
    endtask

    task automatic wait_fin(input bit which_b, input string name);
        int c = 0;
        while (!(which_b ? fin_b : fin_a) && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        check(name, which_b ? fin_b : fin_a, 1'b1);
    endtask

    task automatic wait_rx_a(input int target, input bit need_data, input string name);
        int c = 0;
        @(posedge clk); #2;
        while (!(rx_a >= target && req_a && (!need_data || type_a)) && c < 20000) begin
            @(posedge clk); #2;
            c++;
        end
        check(name, (rx_a >= target) && req_a, 1'b1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 32; i++) begin
            rf_a[i] = 32'hA000_0000 + 32'(i);
            rf_b[i] = 16'hC000 | (16'(i) * 16'h0101);
        end
        sel_a = 8'h00;
        sel_b = 8'h00;
        rstn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs_a", {fin_a, req_a, type_a, dout_a, addr_a, cnt_a}, '0);
        check("rst_outputs_b", {fin_b, req_b, type_b, dout_b, addr_b, cnt_b}, '0);
        @(negedge clk) rstn = 1'b1;

        // T1: full default dump, header latency
        push_dump_a();
        @(negedge clk) sel_a = 8'h52;
        @(posedge clk); #1;
        check("t1_req_lat0", req_a, 1'b0);
        @(posedge clk); #1;
        check("t1_req_lat1", {req_a, type_a, dout_a}, {1'b1, 1'b0, 32'h52});
        wait_fin(1'b0, "t1_finish");
        check("t1_dump_cnt", cnt_a, 8'd1);
        check("t1_queue_empty", exp_a.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        check("t1_finish_held", fin_a, 1'b1);
        @(negedge clk) sel_a = 8'h00;
        @(posedge clk); #1;
        check("t1_finish_drop", {fin_a, cnt_a}, {1'b0, 8'd1});

        // T3: abort while item 5 is requested, then restart
        base    = rx_a;
        stall_a = base + 5;
        exp_a.push_back({1'b0, 32'h52});
        exp_a.push_back({1'b0, 32'h0}); exp_a.push_back({1'b1, 32'hA000_0000});
        exp_a.push_back({1'b0, 32'h1}); exp_a.push_back({1'b1, 32'hA000_0001});
        @(negedge clk) sel_a = 8'h52;
        wait_rx_a(base + 5, 1'b0, "t3_reach_item5");
        sel_a = 8'h00;
        @(posedge clk); #1;
        check("t3_abort_req", req_a, 1'b0);
        check("t3_abort_fin_cnt", {fin_a, cnt_a}, {1'b0, 8'd1});
        check("t3_queue_empty", exp_a.size(), 0);
        repeat (2) @(posedge clk);
        stall_a = -1;
        push_dump_a();
        @(negedge clk) sel_a = 8'h52;
        wait_fin(1'b0, "t3_restart_finish");
        check("t3_dump_cnt", cnt_a, 8'd2);
        check("t3_queue_empty2", exp_a.size(), 0);
        @(negedge clk) sel_a = 8'h00;

        // T4: long ack stall, spurious acks with req low, RF change after capture
        ack_dly_a = 100;
        spur_en_a = 1'b1;
        base = rx_a;
        push_dump_a();
        @(negedge clk) sel_a = 8'h52;
        wait_rx_a(base + 3, 1'b1, "t4_reach_data0");
        rf_a[0] = 32'hDEAD_BEEF;
        repeat (30) @(posedge clk);
        rf_a[0] = 32'hA000_0000;
        wait_fin(1'b0, "t4_finish");
        check("t4_dump_cnt", cnt_a, 8'd3);
        check("t4_queue_empty", exp_a.size(), 0);
        ack_dly_a = 2;
        spur_en_a = 1'b0;
        @(negedge clk) sel_a = 8'h00;
        repeat (2) @(posedge clk);

        // T5: async reset mid-dump, then full dump from header
        base = rx_a;
        push_dump_a();
        @(negedge clk) sel_a = 8'h52;
        wait_rx_a(base + 10, 1'b0, "t5_reach_item10");
        rstn = 1'b0;
        #1;
        check("t5_async_reset", {fin_a, req_a, type_a, dout_a, addr_a, cnt_a}, '0);
        exp_a.delete();
        repeat (3) @(posedge clk);
        push_dump_a();
        @(negedge clk) rstn = 1'b1;
        wait_fin(1'b0, "t5_finish");
        check("t5_dump_cnt", cnt_a, 8'd1);
        check("t5_queue_empty", exp_a.size(), 0);
        @(negedge clk) sel_a = 8'h00;

        // T2/T6: three back-to-back wrapping 16-bit dumps
        for (int d = 0; d < 3; d++) begin
            push_dump_b();
            @(negedge clk) sel_b = 8'h52;
            wait_fin(1'b1, "t6_finish");
            check("t6_dump_cnt", cnt_b, 8'(d + 1));
            check("t6_queue_empty", exp_b.size(), 0);
            repeat (4) @(posedge clk);
            #1;
            check("t6_finish_held", fin_b, 1'b1);
            @(negedge clk) sel_b = 8'h00;
            @(posedge clk); #1;
            check("t6_finish_drop", fin_b, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
